fm_spy_capture: RTL and testbench



---
 rtl/fm_spy_pkg.sv | 24 ++
 rtl/fm_spy_ram.sv | 27 ++
 rtl/fm_spy_capture.sv | 138 +++++++++++++
 tb/tb_fm_spy_capture.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_spy_pkg.sv
// Shared types and sizing helpers for the fm spy capture block.
package fm_spy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_POST    = 3'd2,
    ST_FROZEN  = 3'd3,
    ST_READOUT = 3'd4
  } fm_spy_state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 6;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Counts run 0..DEPTH inclusive, so they need one bit more than an address.
  function automatic int unsigned cnt_w_of(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fm_spy_ram.sv
// Simple dual-port spy memory: one write port, one registered read port (latency 1).
module fm_spy_ram
  import fm_spy_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or its read register, so the tools can map it to block/LUT RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/fm_spy_capture.sv
// Circular spy capture of the fm monitor stream: arm, trigger, freeze, then stream
// the frozen window out oldest-first through a prefetching valid/ready port.
module fm_spy_capture
  import fm_spy_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int POST_TRIG = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mon_data,
  input  logic              mon_vld,
  input  logic              arm,
  input  logic              trigger,
  input  logic              rd_start,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic [2:0]        state_o,
  output logic [ADDR_W:0]   fill_count,
  output logic              overflow
);

  localparam int CNT_W = cnt_w_of(ADDR_W);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(depth_of(ADDR_W));
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_TRIG);

  fm_spy_state_t     state, state_next;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, post_cnt, start_ptr, ram_raddr;
  logic [CNT_W-1:0]  issue_rem, load_rem;
  logic [DATA_W-1:0] ram_q;
  logic              q_vld, wr_en, do_arm, start_rd, issue, load_out, hs_last;

  fm_spy_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (mon_data),
    .re    (issue),
    .raddr (ram_raddr),
    .q     (ram_q)
  );

  // The first read is issued in the rd_start cycle itself so the first word
  // reaches the output register two cycles after rd_start.
  always_comb begin
    wr_en     = mon_vld && (state == ST_ARMED || state == ST_POST);
    do_arm    = arm && (state == ST_IDLE || state == ST_FROZEN);
    start_rd  = (state == ST_FROZEN) && rd_start && !arm;
    start_ptr = (fill_count == FULL) ? wr_ptr : '0;
    ram_raddr = start_rd ? start_ptr : rd_ptr;
    load_out  = q_vld && (!rd_valid || rd_ready);
    hs_last   = rd_valid && rd_ready && rd_last;
    if (start_rd) issue = (fill_count != '0);
    else          issue = (state == ST_READOUT) && (issue_rem != '0) && (!q_vld || load_out);
  end

  // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (arm) state_next = ST_ARMED;
      ST_ARMED:   if (trigger) state_next = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
      ST_POST:    if (wr_en && post_cnt == ADDR_W'(1)) state_next = ST_FROZEN;
      ST_FROZEN: begin
        if (arm)           state_next = ST_ARMED;
        else if (rd_start) state_next = (fill_count == '0) ? ST_IDLE : ST_READOUT;
      end
      ST_READOUT: if (hs_last) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: all registered state below uses non-blocking assignments so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
      issue_rem  <= '0;
      load_rem   <= '0;
      q_vld      <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      if (do_arm) begin
        wr_ptr     <= '0;
        fill_count <= '0;
        overflow   <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (fill_count == FULL) overflow   <= 1'b1;
        else                    fill_count <= fill_count + CNT_W'(1);
      end

      if (state == ST_ARMED && trigger)    post_cnt <= POST_INIT;
      else if (state == ST_POST && wr_en)  post_cnt <= post_cnt - ADDR_W'(1);

      if (start_rd) begin
        rd_ptr    <= start_ptr + ADDR_W'(1);
        issue_rem <= (fill_count == '0) ? '0 : fill_count - CNT_W'(1);
      end else if (issue) begin
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        issue_rem <= issue_rem - CNT_W'(1);
      end

      if (issue)         q_vld <= 1'b1;
      else if (load_out) q_vld <= 1'b0;

      // Output register holds steady while stalled; load_rem counts words not yet presented.
      if (start_rd) begin
        load_rem <= fill_count;
      end else if (load_out) begin
        rd_data  <= ram_q;
        rd_valid <= 1'b1;
        rd_last  <= (load_rem == CNT_W'(1));
        load_rem <= load_rem - CNT_W'(1);
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_fm_spy_capture.sv
// Directed bench for fm_spy_capture: a default-depth instance (POST_TRIG=2) and a
// depth-8 instance (POST_TRIG=0) share clock, reset, monitor stream and rd_ready.
module tb_fm_spy_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mon_data = '0;
  logic        mon_vld = 1'b0;
  logic        rd_ready = 1'b1;

  logic        a_arm = 1'b0, a_trig = 1'b0, a_rds = 1'b0;
  logic [31:0] a_rd_data;
  logic        a_rd_valid, a_rd_last, a_overflow;
  logic [2:0]  a_state;
  logic [6:0]  a_fill;

  logic        b_arm = 1'b0, b_trig = 1'b0, b_rds = 1'b0;
  logic [31:0] b_rd_data;
  logic        b_rd_valid, b_rd_last, b_overflow;
  logic [2:0]  b_state;
  logic [3:0]  b_fill;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_w [16];
  logic [31:0] t1_words [7];

  always #5 clk = ~clk;

  fm_spy_capture #(.DATA_W(32), .ADDR_W(6), .POST_TRIG(2)) dut_a (
    .clk(clk), .rst(rst), .mon_data(mon_data), .mon_vld(mon_vld),
    .arm(a_arm), .trigger(a_trig), .rd_start(a_rds),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_ready(rd_ready), .rd_last(a_rd_last),
    .state_o(a_state), .fill_count(a_fill), .overflow(a_overflow)
  );

  fm_spy_capture #(.DATA_W(32), .ADDR_W(3), .POST_TRIG(0)) dut_b (
    .clk(clk), .rst(rst), .mon_data(mon_data), .mon_vld(mon_vld),
    .arm(b_arm), .trigger(b_trig), .rd_start(b_rds),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(rd_ready), .rd_last(b_rd_last),
    .state_o(b_state), .fill_count(b_fill), .overflow(b_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arm A and feed the five pre-trigger words plus two post-trigger words.
  task automatic capture_a();
    a_arm = 1'b1;
    step();
    a_arm = 1'b0;
    check("a_armed", 32'(a_state), 32'd1);
    for (int i = 0; i < 7; i++) begin
      mon_data = t1_words[i];
      mon_vld  = 1'b1;
      a_trig   = (i == 4);
      step();
      if (i == 4) check("a_post", 32'(a_state), 32'd2);
    end
    mon_vld = 1'b0;
    a_trig  = 1'b0;
    check("a_frozen", 32'(a_state), 32'd3);
    check("a_fill7", 32'(a_fill), 32'd7);
    check("a_ovf0", 32'(a_overflow), 32'd0);
  endtask

  task automatic start_read(input bit use_b);
    if (use_b) b_rds = 1'b1; else a_rds = 1'b1;
    step();
    b_rds = 1'b0;
    a_rds = 1'b0;
    check("rd_lat_state", 32'(use_b ? b_state : a_state), 32'd4);
    check("rd_lat_v0", 32'(use_b ? b_rd_valid : a_rd_valid), 32'd0);
    step();
    check("rd_lat_v1", 32'(use_b ? b_rd_valid : a_rd_valid), 32'd1);
  endtask

  // Collect n_stop of n_total words against exp_w, optionally with rd_ready pattern 1,0,0,1,0,1.
  task automatic drain(input bit use_b, input int n_total, input bit bp, input int n_stop);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [31:0] held = '0;
    logic [5:0]  pat = 6'b101001;
    logic        v, l;
    logic [31:0] d;
    while (got < n_stop && cyc < 200) begin
      rd_ready = bp ? pat[cyc % 6] : 1'b1;
      v = use_b ? b_rd_valid : a_rd_valid;
      d = use_b ? b_rd_data  : a_rd_data;
      l = use_b ? b_rd_last  : a_rd_last;
      if (v) begin
        if (stalled) check("stall_hold", d, held);
        if (rd_ready) begin
          check("rd_data", d, exp_w[got]);
          check("rd_last", 32'(l), 32'(got == n_total - 1));
          got++;
          stalled = 1'b0;
        end else begin
          held    = d;
          stalled = 1'b1;
        end
      end
      step();
      cyc++;
    end
    rd_ready = 1'b1;
    check("rd_count", 32'(got), 32'(n_stop));
    if (n_stop == n_total) begin
      check("rd_end_valid", 32'(use_b ? b_rd_valid : a_rd_valid), 32'd0);
      check("rd_end_state", 32'(use_b ? b_state : a_state), 32'd0);
      check("rd_end_fill", 32'(use_b ? 7'(b_fill) : a_fill), 32'(n_total));
    end
  endtask

  initial begin
    t1_words[0] = 32'h80000BAD; t1_words[1] = 32'h80000BEE; t1_words[2] = 32'h8000D0E5;
    t1_words[3] = 32'h80000FAB; t1_words[4] = 32'h8000DEED; t1_words[5] = 32'h00000001;
    t1_words[6] = 32'h00000002;

    step();
    step();
    rst = 1'b0;
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_valid", 32'(a_rd_valid), 32'd0);
    check("rst_data", a_rd_data, 32'd0);
    check("rst_last", 32'(a_rd_last), 32'd0);
    check("rst_fill", 32'(a_fill), 32'd0);
    check("rst_ovf", 32'(a_overflow), 32'd0);
    check("rst_b_state", 32'(b_state), 32'd0);

    // Test 1: capture and read out in input order.
    for (int i = 0; i < 7; i++) exp_w[i] = t1_words[i];
    capture_a();
    start_read(1'b0);
    drain(1'b0, 7, 1'b0, 7);

    // Test 3: same window read with backpressure.
    capture_a();
    start_read(1'b0);
    drain(1'b0, 7, 1'b1, 7);

    // Test 4: reset after the third handshake, then a clean capture.
    capture_a();
    start_read(1'b0);
    drain(1'b0, 7, 1'b0, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(a_rd_valid), 32'd0);
    check("midrst_state", 32'(a_state), 32'd0);
    check("midrst_fill", 32'(a_fill), 32'd0);
    step();
    check("midrst_quiet", 32'(a_rd_valid), 32'd0);
    capture_a();
    start_read(1'b0);
    drain(1'b0, 7, 1'b0, 7);

    // Test 2: depth-8 instance wraps; oldest surviving word is 4.
    b_arm = 1'b1;
    step();
    b_arm = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mon_data = 32'(i);
      mon_vld  = 1'b1;
      b_trig   = (i == 11);
      step();
    end
    mon_vld = 1'b0;
    b_trig  = 1'b0;
    check("b_frozen", 32'(b_state), 32'd3);
    check("b_fill8", 32'(b_fill), 32'd8);
    check("b_ovf1", 32'(b_overflow), 32'd1);
    for (int i = 0; i < 8; i++) exp_w[i] = 32'(i + 4);
    start_read(1'b1);
    drain(1'b1, 8, 1'b0, 8);

    // Test 5a: arm+trigger in IDLE arms only; a following word does not advance state.
    a_arm  = 1'b1;
    a_trig = 1'b1;
    step();
    a_arm  = 1'b0;
    a_trig = 1'b0;
    check("s5a_armed", 32'(a_state), 32'd1);
    mon_data = 32'hA5A5_0001;
    mon_vld  = 1'b1;
    step();
    mon_vld = 1'b0;
    check("s5a_still_armed", 32'(a_state), 32'd1);

    // Test 5b: trigger with no valid word; two later words still complete the post count.
    a_trig = 1'b1;
    step();
    a_trig = 1'b0;
    check("s5b_post", 32'(a_state), 32'd2);
    step();
    check("s5b_idle_wait", 32'(a_state), 32'd2);
    mon_vld = 1'b1;
    mon_data = 32'hA5A5_0002;
    step();
    check("s5b_post1", 32'(a_state), 32'd2);
    mon_data = 32'hA5A5_0003;
    step();
    mon_vld = 1'b0;
    check("s5b_frozen", 32'(a_state), 32'd3);
    check("s5b_fill", 32'(a_fill), 32'd3);

    // Test 5c: arm+rd_start in FROZEN re-arms with no readout.
    a_arm = 1'b1;
    a_rds = 1'b1;
    step();
    a_arm = 1'b0;
    a_rds = 1'b0;
    check("s5c_armed", 32'(a_state), 32'd1);
    check("s5c_fill", 32'(a_fill), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("s5c_novalid", 32'(a_rd_valid), 32'd0);
    end

    // Test 6: empty window on the POST_TRIG=0 instance.
    b_arm = 1'b1;
    step();
    b_arm  = 1'b0;
    b_trig = 1'b1;
    step();
    b_trig = 1'b0;
    check("s6_frozen", 32'(b_state), 32'd3);
    check("s6_fill", 32'(b_fill), 32'd0);
    b_rds = 1'b1;
    step();
    b_rds = 1'b0;
    check("s6_idle", 32'(b_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("s6_novalid", 32'(b_rd_valid), 32'd0);
      step();
    end
    check("s6_fill_end", 32'(b_fill), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
